// File: rtl/press_classifier.sv
// press_classifier: classifies debounced button edges into short, long and
// double press gestures. It also keeps a running gesture count and a busy flag.
module press_classifier #(
  parameter int LONG_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rise,
  input  logic                   fall,
  output logic                   short_press,
  output logic                   long_press,
  output logic                   double_press,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] event_count
);

  localparam int MAX_CYCLES = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};
  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic          short_next;
  logic          long_next;
  logic          double_next;
  logic          rise_valid;
  logic          fall_valid;

  // A simultaneous rise and fall carries no usable information, so both are dropped.
  assign rise_valid = rise & ~fall;
  assign fall_valid = fall & ~rise;

  // State register and per-state timer. The timer restarts on every state change
  // and saturates at its maximum value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        timer <= '0;
      else if (timer != TIMER_MAX)
        timer <= timer + TW'(1);
    end
  end

  // Next-state and gesture decisions.
  always_comb begin
    state_next  = state;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
    case (state)
      IDLE: begin
        if (rise_valid)
          state_next = PRESSED;
      end
      PRESSED: begin
        // When a release lands on the threshold cycle, the long threshold takes priority.
        if (timer == LONG_LAST) begin
          long_next  = 1'b1;
          state_next = LONG_HELD;
        end else if (fall_valid) begin
          state_next = WAIT_SECOND;
        end
      end
      LONG_HELD: begin
        if (fall_valid)
          state_next = IDLE;
      end
      WAIT_SECOND: begin
        // A second press on the last gap cycle still counts as a double press.
        if (rise_valid) begin
          state_next = SECOND_PRESSED;
        end else if (timer == GAP_LAST) begin
          short_next = 1'b1;
          state_next = IDLE;
        end
      end
      SECOND_PRESSED: begin
        // A release on the threshold cycle goes to IDLE because the button is already up.
        if (fall_valid) begin
          double_next = 1'b1;
          state_next  = IDLE;
        end else if (timer == LONG_LAST) begin
          double_next = 1'b1;
          state_next  = LONG_HELD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered gesture pulses, busy decode and gesture counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
      event_count  <= '0;
    end else begin
      short_press  <= short_next;
      long_press   <= long_next;
      double_press <= double_next;
      busy         <= (state_next != IDLE);
      if (short_next | long_next | double_next)
        event_count <= event_count + COUNT_WIDTH'(1);
    end
  end

endmodule
